// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer for the systolic MAC array: weight load, activation handshake, then compute with
// skewed per-column accumulator write masks across the fill, steady and drain wavefronts.
module systolic_tile_sequencer #(
   parameter int ARRAY_DIM  = 32,
   parameter int PIPE_LAT   = 32,
   parameter int ACC_ADDR_W = 7,
   parameter int LINES_W    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  instr_valid_i,
   output logic                  instr_ready_o,
   input  logic [ACC_ADDR_W-1:0] instr_acc_base_i,
   input  logic [LINES_W-1:0]    instr_lines_i,
   input  logic                  instr_accumulate_i,
   input  logic                  weight_fifo_valid_i,
   input  logic                  activations_rdy_i,
   output logic                  load_weights_o,
   output logic                  load_activations_o,
   output logic                  stall_compute_o,
   output logic                  mac_compute_o,
   output logic                  write_accumulator_o,
   output logic                  read_accumulator_o,
   output logic [ACC_ADDR_W-1:0] accumulator_addr_wr_o,
   output logic [ARRAY_DIM-1:0]  accum_addr_mask_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int CNT_W  = $clog2((2**LINES_W) + PIPE_LAT + ARRAY_DIM) + 1;
   localparam int BEAT_W = $clog2(ARRAY_DIM) + 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_WAIT_ACT, S_COMPUTE, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [CNT_W-1:0]      t_q, t_d;
   logic [ACC_ADDR_W-1:0] base_q, base_d;
   logic [LINES_W-1:0]    lines_q, lines_d;
   logic                  acc_q, acc_d;
   logic [CNT_W-1:0]      last_t;
   logic [CNT_W-1:0]      lines_ext;
   logic                  in_compute;

   logic                  load_w_d, load_act_d, stall_d, mac_d, wr_d, rd_d, busy_d, done_d;
   logic [ACC_ADDR_W-1:0] addr_d;
   logic [ARRAY_DIM-1:0]  mask_d;

   // Final compute cycle is the last drain write: t = PIPE_LAT + N + ARRAY_DIM - 2
   assign last_t        = CNT_W'(PIPE_LAT + ARRAY_DIM - 2) + CNT_W'(lines_q);
   assign instr_ready_o = (state_q == S_IDLE);

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      t_d     = t_q;
      base_d  = base_q;
      lines_d = lines_q;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE: begin
            if (instr_valid_i) begin
               base_d  = instr_acc_base_i;
               lines_d = instr_lines_i;
               acc_d   = instr_accumulate_i;
               beat_d  = '0;
               t_d     = '0;
               state_d = (instr_lines_i == '0) ? S_DONE : S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            if (weight_fifo_valid_i) begin
               if (beat_q == BEAT_W'(ARRAY_DIM - 1)) begin
                  beat_d  = '0;
                  state_d = S_WAIT_ACT;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_WAIT_ACT: begin
            if (activations_rdy_i) begin
               t_d     = '0;
               state_d = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            if (t_q == last_t) begin
               t_d     = '0;
               state_d = S_DONE;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so the registered copies line up with state_q
      in_compute = (state_d == S_COMPUTE);
      lines_ext  = CNT_W'(lines_d);
      load_w_d   = (state_d == S_LOAD_W);
      load_act_d = (state_d == S_WAIT_ACT) || (in_compute && (t_d < lines_ext));
      stall_d    = !in_compute;
      mac_d      = in_compute;
      wr_d       = in_compute && (t_d >= CNT_W'(PIPE_LAT));
      rd_d       = wr_d && acc_d;
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      addr_d     = wr_d ? (base_d + ACC_ADDR_W'(t_d - CNT_W'(PIPE_LAT))) : accumulator_addr_wr_o;
      mask_d     = '0;
      // Column j sees its N rows j cycles after column 0; mask MSB is column 0
      for (int j = 0; j < ARRAY_DIM; j++) begin
         if (wr_d && (t_d >= CNT_W'(PIPE_LAT + j)) && (t_d < CNT_W'(PIPE_LAT + j) + lines_ext))
            mask_d[ARRAY_DIM-1-j] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q               <= S_IDLE;
         beat_q                <= '0;
         t_q                   <= '0;
         base_q                <= '0;
         lines_q               <= '0;
         acc_q                 <= 1'b0;
         load_weights_o        <= 1'b0;
         load_activations_o    <= 1'b0;
         stall_compute_o       <= 1'b1;
         mac_compute_o         <= 1'b0;
         write_accumulator_o   <= 1'b0;
         read_accumulator_o    <= 1'b0;
         accumulator_addr_wr_o <= '0;
         accum_addr_mask_o     <= '0;
         busy_o                <= 1'b0;
         done_o                <= 1'b0;
      end else begin
         state_q               <= state_d;
         beat_q                <= beat_d;
         t_q                   <= t_d;
         base_q                <= base_d;
         lines_q               <= lines_d;
         acc_q                 <= acc_d;
         load_weights_o        <= load_w_d;
         load_activations_o    <= load_act_d;
         stall_compute_o       <= stall_d;
         mac_compute_o         <= mac_d;
         write_accumulator_o   <= wr_d;
         read_accumulator_o    <= rd_d;
         accumulator_addr_wr_o <= addr_d;
         accum_addr_mask_o     <= mask_d;
         busy_o                <= busy_d;
         done_o                <= done_d;
      end
   end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Directed bench for systolic_tile_sequencer with ARRAY_DIM=4, PIPE_LAT=4, ACC_ADDR_W=7.
module tb_systolic_tile_sequencer;

   logic       clk_i;
   logic       rst_i;
   logic       instr_valid_i;
   logic       instr_ready_o;
   logic [6:0] instr_acc_base_i;
   logic [15:0] instr_lines_i;
   logic       instr_accumulate_i;
   logic       weight_fifo_valid_i;
   logic       activations_rdy_i;
   logic       load_weights_o;
   logic       load_activations_o;
   logic       stall_compute_o;
   logic       mac_compute_o;
   logic       write_accumulator_o;
   logic       read_accumulator_o;
   logic [6:0] accumulator_addr_wr_o;
   logic [3:0] accum_addr_mask_o;
   logic       busy_o;
   logic       done_o;

   systolic_tile_sequencer #(
      .ARRAY_DIM(4), .PIPE_LAT(4), .ACC_ADDR_W(7), .LINES_W(16)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
      .instr_acc_base_i(instr_acc_base_i), .instr_lines_i(instr_lines_i),
      .instr_accumulate_i(instr_accumulate_i),
      .weight_fifo_valid_i(weight_fifo_valid_i), .activations_rdy_i(activations_rdy_i),
      .load_weights_o(load_weights_o), .load_activations_o(load_activations_o),
      .stall_compute_o(stall_compute_o), .mac_compute_o(mac_compute_o),
      .write_accumulator_o(write_accumulator_o), .read_accumulator_o(read_accumulator_o),
      .accumulator_addr_wr_o(accumulator_addr_wr_o), .accum_addr_mask_o(accum_addr_mask_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int passed = 0;
   int fails  = 0;
   int total  = 0;

   int n_load, n_act, n_mac, n_rd, n_stray, n_done, done_cyc;
   bit finished;
   logic [6:0] wr_addr[$];
   logic [3:0] wr_mask[$];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [6:0] base, input logic [15:0] lines, input logic acc);
      weight_fifo_valid_i = 1'b1;
      instr_acc_base_i    = base;
      instr_lines_i       = lines;
      instr_accumulate_i  = acc;
      instr_valid_i       = 1'b1;
      tick();
      instr_valid_i       = 1'b0;
   endtask

   // Starts on the first cycle after the accepting edge; runs until done_o or the cycle budget
   task automatic collect(input string pfx, input bit toggle);
      n_load = 0; n_act = 0; n_mac = 0; n_rd = 0; n_stray = 0; n_done = 0;
      done_cyc = -1; finished = 1'b0;
      wr_addr.delete();
      wr_mask.delete();
      for (int c = 0; c < 200; c++) begin
         if (load_weights_o) begin
            weight_fifo_valid_i = toggle ? ((n_load % 2) == 0) : 1'b1;
            n_load++;
         end
         if (load_activations_o) n_act++;
         if (mac_compute_o) n_mac++;
         if (write_accumulator_o) begin
            wr_addr.push_back(accumulator_addr_wr_o);
            wr_mask.push_back(accum_addr_mask_o);
         end
         if (read_accumulator_o) n_rd++;
         if (read_accumulator_o !== write_accumulator_o && read_accumulator_o) n_stray++;
         if (!write_accumulator_o && accum_addr_mask_o != 4'd0) n_stray++;
         if (done_o) begin
            n_done++;
            done_cyc = c;
            finished = 1'b1;
            break;
         end
         tick();
      end
      chk({pfx, " finished"}, finished, 1);
      tick();
      chk({pfx, " done_1cyc"}, done_o, 0);
      chk({pfx, " ready_after"}, instr_ready_o, 1);
   endtask

   task automatic check_writes(input string pfx, input int n, input logic [6:0] base,
                               input logic [35:0] masks);
      chk({pfx, " n_wr"}, wr_addr.size(), n);
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
         chk($sformatf("%s addr%0d", pfx, i), wr_addr[i], 7'(base + 7'(i)));
         chk($sformatf("%s mask%0d", pfx, i), wr_mask[i], masks[35-4*i -: 4]);
      end
   endtask

   initial begin
      bit found;
      int nd;
      rst_i = 1'b1;
      instr_valid_i = 1'b0;
      instr_acc_base_i = '0;
      instr_lines_i = '0;
      instr_accumulate_i = 1'b0;
      weight_fifo_valid_i = 1'b1;
      activations_rdy_i = 1'b1;
      #7;
      chk("rst ready", instr_ready_o, 1);
      chk("rst stall", stall_compute_o, 1);
      chk("rst busy", busy_o, 0);
      chk("rst done", done_o, 0);
      chk("rst wr", write_accumulator_o, 0);
      chk("rst mask", accum_addr_mask_o, 0);
      chk("rst loadw", load_weights_o, 0);
      rst_i = 1'b0;
      tick();

      // N=6 base=10 overwrite, weights every cycle
      issue(7'd10, 16'd6, 1'b0);
      chk("t1 busy", busy_o, 1);
      collect("t1", 1'b0);
      chk("t1 n_load", n_load, 4);
      chk("t1 n_act", n_act, 7);
      chk("t1 n_mac", n_mac, 13);
      chk("t1 n_rd", n_rd, 0);
      chk("t1 stray", n_stray, 0);
      chk("t1 n_done", n_done, 1);
      check_writes("t1", 9, 7'd10, 36'h8CEFFF731);

      // Same with weight valid toggling 1,0,1,0...
      issue(7'd10, 16'd6, 1'b0);
      collect("t2", 1'b1);
      chk("t2 n_load", n_load, 7);
      chk("t2 n_done", n_done, 1);
      check_writes("t2", 9, 7'd10, 36'h8CEFFF731);

      // N=2 base=126 accumulate, address wraps
      issue(7'd126, 16'd2, 1'b1);
      collect("t3", 1'b0);
      chk("t3 n_rd", n_rd, 5);
      chk("t3 stray", n_stray, 0);
      chk("t3 n_mac", n_mac, 9);
      check_writes("t3", 5, 7'd126, 36'h8C6310000);

      // N=0 goes straight to DONE
      issue(7'd33, 16'd0, 1'b0);
      collect("t4", 1'b0);
      chk("t4 done_cyc", done_cyc, 0);
      chk("t4 n_load", n_load, 0);
      chk("t4 n_mac", n_mac, 0);
      chk("t4 n_wr", wr_addr.size(), 0);

      // Reset at w=3 of an N=6 run
      issue(7'd10, 16'd6, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (write_accumulator_o && accumulator_addr_wr_o == 7'd13) found = 1'b1;
         else tick();
      end
      chk("t5 reached w3", found, 1);
      chk("t5 w3 mask", accum_addr_mask_o, 4'hF);
      #2 rst_i = 1'b1;
      #1;
      chk("t5 rst ready", instr_ready_o, 1);
      chk("t5 rst stall", stall_compute_o, 1);
      chk("t5 rst busy", busy_o, 0);
      chk("t5 rst wr", write_accumulator_o, 0);
      chk("t5 rst mac", mac_compute_o, 0);
      chk("t5 rst mask", accum_addr_mask_o, 0);
      chk("t5 rst addr", accumulator_addr_wr_o, 0);
      tick();
      rst_i = 1'b0;
      nd = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (done_o) nd++;
      end
      chk("t5 no done", nd, 0);
      chk("t5 idle busy", busy_o, 0);
      issue(7'd5, 16'd1, 1'b0);
      collect("t5b", 1'b0);
      chk("t5b n_mac", n_mac, 8);
      chk("t5b n_done", n_done, 1);
      check_writes("t5b", 4, 7'd5, 36'h842100000);

      // Valid held high across two instructions
      instr_acc_base_i = 7'd0;
      instr_lines_i = 16'd0;
      instr_accumulate_i = 1'b0;
      instr_valid_i = 1'b1;
      tick();
      instr_acc_base_i = 7'd20;
      instr_lines_i = 16'd1;
      chk("t6 done", done_o, 1);
      chk("t6 ready in done", instr_ready_o, 0);
      tick();
      chk("t6 idle ready", instr_ready_o, 1);
      chk("t6 idle busy", busy_o, 0);
      chk("t6 idle done", done_o, 0);
      tick();
      instr_valid_i = 1'b0;
      chk("t6 second accepted", load_weights_o, 1);
      chk("t6 second busy", busy_o, 1);
      collect("t6", 1'b0);
      chk("t6 n_load", n_load, 4);
      check_writes("t6", 4, 7'd20, 36'h842100000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
